// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory arbiter slice: access size codes
// and the arbiter FSM state encoding.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory masters, the arbiter and the
// 1024x32 data memory.
interface dmem_arbiter_if #(
    parameter int AW = 12
);
    logic          req0, req1;
    logic          we0, we1;
    logic [1:0]    size0, size1;
    logic          uns0, uns1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   wdata0, wdata1;
    logic          ack0, ack1;
    logic          err0, err1;
    logic [31:0]   rdata0, rdata1;
    logic          busy;
    logic          ram_rw;
    logic [3:0]    ram_sel;
    logic [AW-3:0] ram_addr;
    logic [31:0]   ram_data_in;
    logic [31:0]   ram_data_out;

    modport slave (
        input  req0, req1, we0, we1, size0, size1, uns0, uns1,
        input  addr0, addr1, wdata0, wdata1, ram_data_out,
        output ack0, ack1, err0, err1, rdata0, rdata1, busy,
        output ram_rw, ram_sel, ram_addr, ram_data_in
    );

    modport master (
        output req0, req1, we0, we1, size0, size1, uns0, uns1,
        output addr0, addr1, wdata0, wdata1, ram_data_out,
        input  ack0, ack1, err0, err1, rdata0, rdata1, busy,
        input  ram_rw, ram_sel, ram_addr, ram_data_in
    );
endinterface

// File: rtl/dmem_lane.sv
// Byte-lane logic: lane select, lane-replicated store data, load extension
// from an LSB-justified memory lane, and alignment check.
module dmem_lane
    import mem_pkg::*;
(
    input  size_t       size,
    input  logic        uns,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] ram_data_out,
    output logic [3:0]  sel,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    always_comb begin
        sel        = '0;
        wdata_lane = '0;
        rdata_ext  = '0;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                sel        = 4'b0001 << addr;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{~uns & ram_data_out[7]}}, ram_data_out[7:0]};
            end
            SZ_HALF: begin
                sel        = addr[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{~uns & ram_data_out[15]}}, ram_data_out[15:0]};
                misaligned = addr[0];
            end
            SZ_WORD: begin
                sel        = '1;
                wdata_lane = wdata;
                rdata_ext  = ram_data_out;
                misaligned = (addr != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the 1024x32 byte-lane data memory.
// Serialises accesses, drives the memory and returns extended load data.
module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int AW = 12
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);

    state_t        state, state_nxt;
    logic          last_grant, gnt_valid, gnt_port, grant;
    logic          r_port, r_we, r_uns, r_err;
    size_t         r_size;
    logic          rw_q;
    logic [3:0]    sel_q;
    logic [AW-3:0] addr_q;
    logic [31:0]   data_q;

    logic          in_we, in_uns;
    logic [1:0]    in_size;
    logic [AW-1:0] in_addr;
    logic [31:0]   in_wdata;

    size_t         l_size;
    logic          l_uns, l_mis;
    logic [3:0]    l_sel;
    logic [31:0]   l_wdata, l_rdata;
    logic          resp, ack0_i, ack1_i;

    always_comb begin
        gnt_valid = bus.req0 | bus.req1;
        gnt_port  = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;
        grant     = (state == IDLE) & gnt_valid;
        in_we     = gnt_port ? bus.we1    : bus.we0;
        in_size   = gnt_port ? bus.size1  : bus.size0;
        in_uns    = gnt_port ? bus.uns1   : bus.uns0;
        in_addr   = gnt_port ? bus.addr1  : bus.addr0;
        in_wdata  = gnt_port ? bus.wdata1 : bus.wdata0;
    end

    // One lane unit serves both phases: IDLE checks and positions the incoming
    // request, RESP extends the returned lane using the latched size/uns.
    always_comb begin
        l_size = (state == IDLE) ? size_t'(in_size) : r_size;
        l_uns  = (state == IDLE) ? in_uns : r_uns;
    end

    dmem_lane u_lane (
        .size         (l_size),
        .uns          (l_uns),
        .addr         (in_addr[1:0]),
        .wdata        (in_wdata),
        .ram_data_out (bus.ram_data_out),
        .sel          (l_sel),
        .wdata_lane   (l_wdata),
        .rdata_ext    (l_rdata),
        .misaligned   (l_mis)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = l_mis ? RESP : ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-facing signals are registered at grant so they are live only
    // for the single ACCESS cycle; address and store data hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            r_port     <= 1'b0;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= SZ_BYTE;
            rw_q       <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else if (grant) begin
            last_grant <= gnt_port;
            r_port     <= gnt_port;
            r_we       <= in_we;
            r_uns      <= in_uns;
            r_err      <= l_mis;
            r_size     <= size_t'(in_size);
            if (l_mis) begin
                rw_q  <= 1'b0;
                sel_q <= '0;
            end else begin
                rw_q   <= in_we;
                sel_q  <= l_sel;
                addr_q <= in_addr[AW-1:2];
                data_q <= l_wdata;
            end
        end else begin
            rw_q  <= 1'b0;
            sel_q <= '0;
        end
    end

    always_comb begin
        resp            = (state == RESP) & ~rst;
        ack0_i          = resp & ~r_port;
        ack1_i          = resp & r_port;
        bus.ack0        = ack0_i;
        bus.ack1        = ack1_i;
        bus.err0        = ack0_i & r_err;
        bus.err1        = ack1_i & r_err;
        bus.rdata0      = (ack0_i & ~r_we & ~r_err) ? l_rdata : '0;
        bus.rdata1      = (ack1_i & ~r_we & ~r_err) ? l_rdata : '0;
        bus.busy        = (state != IDLE);
        bus.ram_rw      = rw_q & ~rst;
        bus.ram_sel     = sel_q;
        bus.ram_addr    = addr_q;
        bus.ram_data_in = data_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte-array reference model, a
// lane-returning memory model, directed scenarios and randomized traffic.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dmem_arbiter_if #(.AW(12)) bus ();
    dmem_arbiter #(.AW(12)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Memory model: registered read returning the selected lanes at the LSB.
    logic [31:0] mem [1024] = '{default: 32'h0};
    logic [7:0]  ref_mem [4096] = '{default: 8'h00};
    int          wr_cnt = 0, sel_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
    logic [3:0]  last_sel = '0;
    logic [31:0] last_din = '0;
    logic [9:0]  last_addr = '0;

    function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [3:0] s);
        case (s)
            4'b0001: return {24'h0, w[7:0]};
            4'b0010: return {24'h0, w[15:8]};
            4'b0100: return {24'h0, w[23:16]};
            4'b1000: return {24'h0, w[31:24]};
            4'b0011: return {16'h0, w[15:0]};
            4'b1100: return {16'h0, w[31:16]};
            4'b1111: return w;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.ram_rw) begin
            for (int i = 0; i < 4; i++)
                if (bus.ram_sel[i]) mem[bus.ram_addr][8*i +: 8] <= bus.ram_data_in[8*i +: 8];
            wr_cnt <= wr_cnt + 1;
        end else if (bus.ram_sel != 4'b0000) begin
            bus.ram_data_out <= lane_extract(mem[bus.ram_addr], bus.ram_sel);
        end
        if (bus.ram_sel != 4'b0000) begin
            sel_cnt   <= sel_cnt + 1;
            last_sel  <= bus.ram_sel;
            last_din  <= bus.ram_data_in;
            last_addr <= bus.ram_addr;
        end
        if (bus.ack0) ack0_cnt <= ack0_cnt + 1;
        if (bus.ack1) ack1_cnt <= ack1_cnt + 1;
    end

    // Reference model in byte-addressed terms.
    function automatic logic model_err(input logic [1:0] sz, input logic [11:0] a);
        return (sz == 2'b11) || ((int'(a) % (1 << sz)) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [11:0] a);
        int n = 1 << sz;
        logic [63:0] v = 64'h0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v[31:0];
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [11:0] a, input logic [31:0] wd);
        int n = 1 << sz;
        for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    endtask

    task automatic drive(input int p, input logic r, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [11:0] a, input logic [31:0] wd);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = we; bus.size0 = sz; bus.uns0 = uns; bus.addr0 = a; bus.wdata0 = wd;
        end else begin
            bus.req1 = r; bus.we1 = we; bus.size1 = sz; bus.uns1 = uns; bus.addr1 = a; bus.wdata1 = wd;
        end
    endtask

    // One access on port p; lat counts cycles after the sampling edge (err: 0, valid: 1).
    task automatic access(input int p, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [11:0] a, input logic [31:0] wd,
                          output int lat, output logic er, output logic [31:0] rd);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_wait: busy=%b required 0", bus.busy); end
        drive(p, 1'b1, we, sz, uns, a, wd);
        @(posedge clk); #1;
        drive(p, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), 12'($urandom), $urandom);
        lat = -1; er = 1'b0; rd = '0;
        for (int c = 0; c < 6; c++) begin
            if ((p == 0) ? bus.ack0 : bus.ack1) begin
                lat = c;
                er  = (p == 0) ? bus.err0 : bus.err1;
                rd  = (p == 0) ? bus.rdata0 : bus.rdata1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.ack0, bus.ack1, bus.err0, bus.err1} !== 4'b0000) begin
            errors++; $display("FAIL reset_ack_err: got %b required 0000", {bus.ack0, bus.ack1, bus.err0, bus.err1});
        end
        checks++;
        if ({bus.busy, bus.ram_rw, bus.ram_sel} !== 6'b0) begin
            errors++; $display("FAIL reset_busy_rw_sel: got %b required 000000", {bus.busy, bus.ram_rw, bus.ram_sel});
        end
        checks++;
        if ({bus.rdata0, bus.rdata1} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h %h required 0", bus.rdata0, bus.rdata1);
        end
        checks++;
        if ({bus.ram_addr, bus.ram_data_in} !== 42'h0) begin
            errors++; $display("FAIL reset_ram_addr_data: got %h %h required 0", bus.ram_addr, bus.ram_data_in);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_byte();
        int lat, w0; logic er; logic [31:0] rd;
        w0 = wr_cnt;
        access(0, 1'b1, 2'b00, 1'b0, 12'h006, 32'h00000080, lat, er, rd);
        model_store(2'b00, 12'h006, 32'h00000080);
        checks++;
        if (lat !== 1 || er !== 1'b0) begin errors++; $display("FAIL byte_store_ack: lat=%0d err=%b required 1/0", lat, er); end
        checks++;
        if (last_sel !== 4'b0100 || last_din !== 32'h80808080) begin
            errors++; $display("FAIL byte_store_lanes: sel=%b din=%h required 0100/80808080", last_sel, last_din);
        end
        checks++;
        if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL byte_store_wr: got %0d required 1", wr_cnt - w0); end
        access(0, 1'b0, 2'b00, 1'b0, 12'h006, 32'h0, lat, er, rd);
        checks++;
        if (lat !== 1 || rd !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_load_signed: lat=%0d rd=%h required 1/ffffff80", lat, rd); end
        access(0, 1'b0, 2'b00, 1'b1, 12'h006, 32'h0, lat, er, rd);
        checks++;
        if (rd !== 32'h00000080) begin errors++; $display("FAIL byte_load_unsigned: got %h required 00000080", rd); end
    endtask

    task automatic test_half_word();
        int lat; logic er; logic [31:0] rd;
        access(0, 1'b1, 2'b10, 1'b0, 12'h010, 32'h12345678, lat, er, rd);
        model_store(2'b10, 12'h010, 32'h12345678);
        checks++;
        if (last_sel !== 4'b1111 || last_din !== 32'h12345678 || last_addr !== 10'd4) begin
            errors++; $display("FAIL word_store_bus: sel=%b din=%h addr=%h required 1111/12345678/004", last_sel, last_din, last_addr);
        end
        access(0, 1'b0, 2'b01, 1'b0, 12'h012, 32'h0, lat, er, rd);
        checks++;
        if (last_sel !== 4'b1100 || rd !== 32'h00001234) begin
            errors++; $display("FAIL half_load: sel=%b rd=%h required 1100/00001234", last_sel, rd);
        end
        access(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, lat, er, rd);
        checks++;
        if (rd !== 32'h12345678 || er !== 1'b0) begin errors++; $display("FAIL word_load: rd=%h err=%b required 12345678/0", rd, er); end
    endtask

    task automatic test_misalign();
        logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b01};
        logic [11:0] ad [4] = '{12'h005, 12'h003, 12'h008, 12'h001};
        logic        we [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int lat, w0, s0; logic er; logic [31:0] rd;
        for (int k = 0; k < 4; k++) begin
            w0 = wr_cnt; s0 = sel_cnt;
            access(k % 2, we[k], sz[k], 1'b0, ad[k], 32'hA5A5A5A5, lat, er, rd);
            checks++;
            if (lat !== 0 || er !== 1'b1 || rd !== 32'h0) begin
                errors++; $display("FAIL misalign_%0d: lat=%0d err=%b rd=%h required 0/1/0", k, lat, er, rd);
            end
            checks++;
            if (wr_cnt !== w0 || sel_cnt !== s0) begin
                errors++; $display("FAIL misalign_mem_%0d: writes=%0d selects=%0d required 0/0", k, wr_cnt - w0, sel_cnt - s0);
            end
        end
    endtask

    task automatic test_random();
        int p, lat, w0, a0, a1, exp_lat; logic we, uns, er, exp_err; logic [1:0] sz;
        logic [11:0] a; logic [31:0] wd, rd, exp_rd;
        for (int it = 0; it < 150; it++) begin
            p   = int'($urandom_range(0, 1));
            we  = 1'($urandom);
            sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            uns = 1'($urandom);
            a   = 12'h100 + 12'($urandom_range(0, 63));
            wd  = $urandom;
            exp_err = model_err(sz, a);
            exp_lat = exp_err ? 0 : 1;
            exp_rd  = (exp_err || we) ? 32'h0 : model_load(sz, uns, a);
            w0 = wr_cnt; a0 = ack0_cnt; a1 = ack1_cnt;
            access(p, we, sz, uns, a, wd, lat, er, rd);
            if (!exp_err && we) model_store(sz, a, wd);
            checks++;
            if (lat !== exp_lat || er !== exp_err || rd !== exp_rd) begin
                errors++;
                $display("FAIL rand_%0d p%0d we=%b sz=%b a=%h: lat=%0d err=%b rd=%h required %0d/%b/%h",
                         it, p, we, sz, a, lat, er, rd, exp_lat, exp_err, exp_rd);
            end
            checks++;
            if (wr_cnt - w0 !== ((we && !exp_err) ? 1 : 0)) begin
                errors++; $display("FAIL rand_wr_%0d: got %0d writes required %0d", it, wr_cnt - w0, (we && !exp_err) ? 1 : 0);
            end
            checks++;
            if ((ack0_cnt - a0) !== ((p == 0) ? 1 : 0) || (ack1_cnt - a1) !== ((p == 1) ? 1 : 0)) begin
                errors++; $display("FAIL rand_acks_%0d: ack0=%0d ack1=%0d for port %0d", it, ack0_cnt - a0, ack1_cnt - a1, p);
            end
        end
    endtask

    task automatic test_contention();
        logic [31:0] w [2]; logic [11:0] pa [2] = '{12'h200, 12'h204};
        int phase [2] = '{0, 0};
        int exp_port = 0, prev = -1, nack = 0, p;
        logic er; logic [31:0] rd, exp;
        w[0] = $urandom; w[1] = $urandom;
        @(negedge clk); rst = 1'b1;
        drive(0, 1'b1, 1'b1, 2'b10, 1'b0, pa[0], w[0]);
        drive(1, 1'b1, 1'b1, 2'b10, 1'b0, pa[1], w[1]);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 30 && nack < 6; c++) begin
            @(posedge clk); #1;
            if (bus.ack0 || bus.ack1) begin
                p  = bus.ack1 ? 1 : 0;
                er = (p == 0) ? bus.err0 : bus.err1;
                rd = (p == 0) ? bus.rdata0 : bus.rdata1;
                checks++;
                if (bus.ack0 && bus.ack1) begin errors++; $display("FAIL tie_double_ack: both acks at cycle %0d", c); end
                checks++;
                if (p !== exp_port) begin errors++; $display("FAIL tie_order: ack on port %0d required %0d", p, exp_port); end
                if (prev >= 0) begin
                    checks++;
                    if (c - prev !== 3) begin errors++; $display("FAIL tie_spacing: %0d cycles required 3", c - prev); end
                end
                exp = (phase[p] == 0) ? 32'h0 : model_load(2'b10, 1'b0, pa[p]);
                checks++;
                if (er !== 1'b0 || rd !== exp) begin errors++; $display("FAIL tie_data_p%0d: err=%b rd=%h required 0/%h", p, er, rd, exp); end
                if (phase[p] == 0) begin
                    model_store(2'b10, pa[p], w[p]);
                    drive(p, 1'b1, 1'b0, 2'b10, 1'b0, pa[p], 32'h0);
                    phase[p] = 1;
                end
                prev = c; exp_port = 1 - p; nack++;
            end
        end
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
        checks++;
        if (nack !== 6) begin errors++; $display("FAIL tie_timeout: %0d acks required 6", nack); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n = 0, w0, a0, a1, nack = 0; logic [31:0] exp;
        @(negedge clk);
        while (bus.busy && n < 10) begin @(negedge clk); n++; end
        drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 12'h300, 32'hDEADBEEF);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
        w0 = wr_cnt; a1 = ack1_cnt;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_access: busy=%b required 1", bus.busy); end
        rst = 1'b1; #1;
        checks++;
        if (bus.ram_rw !== 1'b0) begin errors++; $display("FAIL rstmid_rw: ram_rw=%b required 0", bus.ram_rw); end
        @(posedge clk); #1;
        checks++;
        if ({bus.busy, bus.ack1, bus.ram_sel, bus.ram_addr, bus.ram_data_in} !== 48'h0) begin
            errors++; $display("FAIL rstmid_outputs: busy=%b ack1=%b sel=%b addr=%h din=%h required 0",
                               bus.busy, bus.ack1, bus.ram_sel, bus.ram_addr, bus.ram_data_in);
        end
        @(negedge clk); rst = 1'b0;
        // Tie immediately after release: port 0 reads the suppressed address.
        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 12'h300, 32'h0);
        drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 12'h204, 32'h0);
        a0 = ack0_cnt;
        for (int c = 0; c < 12 && nack < 2; c++) begin
            @(posedge clk); #1;
            if (bus.ack0 && nack == 0) begin
                checks++;
                if (bus.rdata0 !== 32'h0) begin errors++; $display("FAIL rstmid_load: rd=%h required 00000000", bus.rdata0); end
                drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
                nack++;
            end else if (bus.ack1) begin
                exp = model_load(2'b10, 1'b0, 12'h204);
                checks++;
                if (nack !== 1 || bus.rdata1 !== exp) begin
                    errors++; $display("FAIL rstmid_tie: port1 ack as #%0d rd=%h required #1/%h", nack, bus.rdata1, exp);
                end
                drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
                nack++;
            end
        end
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
        @(posedge clk); #1;
        checks++;
        if (nack !== 2 || ack0_cnt - a0 !== 1 || ack1_cnt - a1 !== 1 || wr_cnt !== w0) begin
            errors++; $display("FAIL rstmid_counts: acks=%0d ack0=%0d ack1=%0d writes=%0d required 2/1/1/0",
                               nack, ack0_cnt - a0, ack1_cnt - a1, wr_cnt - w0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_byte();
        test_half_word();
        test_misalign();
        test_random();
        test_contention();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbitrating controller for the 1024×32 data memory with byte-lane selects. Sits between the data memory and its two masters: port 0, the pipeline MEM stage, and port 1, the debug/program loader. It serialises their byte-addressed accesses and, for loads, returns sign- or zero-extended data. It drives the word address, lane select and lane-positioned store data, and checks alignment.

## Interface
- `AW`, default 12: byte-address width (word address = `AW-2` = 10 bits).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req0`/`req1` in 1: access request, port 0/1.
- `we0`/`we1` in 1: 1 = store, 0 = load.
- `size0`/`size1` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `uns0`/`uns1` in 1: load zero-extends when 1.
- `addr0`/`addr1` in AW: byte address.
- `wdata0`/`wdata1` in 32: store data, LSB-justified.
- `ack0`/`ack1` out 1: one-cycle completion pulse.
- `err0`/`err1` out 1: valid with ack; access was rejected.
- `rdata0`/`rdata1` out 32: load result, valid with ack.
- `busy` out 1: high in every state except IDLE.
- `ram_rw` out 1: memory write enable.
- `ram_sel` out 4: byte-lane select.
- `ram_addr` out 10: word address.
- `ram_data_in` out 32: lane-positioned store data.
- `ram_data_out` in 32: memory read data.
  - Registered, so it is valid the cycle after the read is issued.
  - The selected lane arrives at the LSB, zero-filled above it.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - Sample `req0`/`req1`.
  - Arbitration is round-robin: if both are high, grant the port not granted last. `last_grant` resets to 1, so port 0 wins the first tie.
  - Latch the granted port's `we`, `size`, `uns`, `addr`, `wdata` and the port id.
  - If the access is misaligned, or `size`=11, go to RESP with the error flag set. Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Otherwise go to ACCESS.
- **ACCESS**
  - Memory signals are driven from registered copies of the latched request.
  - `ram_addr` = `addr[AW-1:2]`.
  - `ram_sel`:
    - byte: `0001 << addr[1:0]`
    - half: `0011` when `addr[1]`=0, `1100` when `addr[1]`=1
    - word: `1111`
  - `ram_data_in`:
    - byte: `{4{wdata[7:0]}}`
    - half: `{2{wdata[15:0]}}`
    - word: `wdata`
  - `ram_rw` = `we`. Always go to RESP.
- **RESP**
  - Pulse `ack` on the granted port only; drive `err` with it.
  - `rdata` is produced combinationally from `ram_data_out`:
    - byte: sign-extend from bit 7 unless `uns`.
    - half: sign-extend from bit 15 unless `uns`.
    - word: pass through.
  - `rdata` is 0 for stores and for errors.
  - Always go to IDLE.
- Outside ACCESS: `ram_rw`=0, `ram_sel`=0000, and `ram_addr`/`ram_data_in` are held.
- Update `last_grant` only on a grant.
- The non-granted port sees no ack and simply keeps `req` high.
- A `req` still high in the IDLE cycle after its ack is a new access. Masters drop `req` on seeing ack unless they intend back-to-back accesses.

## Timing
- Valid access: request sampled at edge t; ACCESS in cycle t+1; ack and rdata in cycle t+2. A store commits at the end of cycle t+1.
- Error path: ack with err in cycle t+1; the memory is never touched.
- Throughput: one access per 3 cycles; a waiting port is served at most 3 cycles after the other port's grant.
- Request fields must be stable only in the cycle they are sampled.
- Reset, including mid-operation:
  - State goes to IDLE and the in-flight access is dropped; no ack is issued.
  - All outputs go to 0: `ack*`, `err*`, `rdata*`, `busy`, `ram_rw`, `ram_sel`, `ram_addr`, `ram_data_in`.
  - `last_grant` goes to 1.
  - A store cut off in ACCESS is suppressed, because `ram_rw` is forced to 0 while `rst` is high.

## Structure
- Shared package `mem_pkg`:
  - size codes `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`
  - state encoding (IDLE/ACCESS/RESP)
- One combinational sub-module, `dmem_lane`. Inputs: `size`, `uns`, `addr[1:0]`, `wdata`, `ram_data_out`. Outputs: `sel`, lane-positioned write data, extended read data, misaligned flag.

## Test plan
- **Byte store and sign-extended load:** port 0 stores byte 0x80 at addr 0x006, then does a signed byte load from 0x006.
  - Store: `ram_sel`=0100, `ram_data_in`=0x80808080.
  - Load: `rdata0`=0xFFFFFF80 in cycle t+2.
  - The same load with `uns0`=1 returns 0x00000080.
- **Half and word:** port 0 stores word 0x12345678 at 0x010, then loads half from 0x012.
  - Signed half load: `ram_sel`=1100, `rdata0`=0x00001234.
  - Word load from 0x010: 0x12345678.
- **Misalignment:** word load at 0x005 gives `ack0`=`err0`=1 in t+1 with `ram_rw`=0 throughout. A half at 0x003 behaves the same, as does any access with `size`=11.
- **Contention:** `req0`=`req1`=1 held from reset.
  - Grants are 0, 1, 0, 1, …; acks arrive 3 cycles apart.
  - Each `rdata` matches what that port stored.
- **Reset mid-operation:** assert `rst` during the ACCESS cycle of a port-1 store of 0xDEADBEEF.
  - No ack is issued and `ram_rw`=0 in that cycle.
  - After release, a load of that address returns 0.
  - The first tie goes to port 0.
